// File: rtl/display_pkg.sv
// Shared display-path constants, colours and the box-drawer state encoding.
package display_pkg;

    localparam int SCREEN_W   = 240;
    localparam int SCREEN_H   = 180;
    localparam int LANE_X0    = 40;
    localparam int LANE_PITCH = 60;

    localparam logic [2:0] C_NOTE = 3'b010;
    localparam logic [2:0] C_BG   = 3'b000;

    // Lane index that means "nothing to draw for this slot".
    localparam logic [1:0] NO_BOX = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOADED = 2'd1,
        S_DRAW   = 2'd2,
        S_DONE   = 2'd3
    } drawState_t;

endpackage

// File: rtl/pixel_scan_counter.sv
// Nested dx/dy raster counter; dx is the inner loop. Exposes the post-edge value
// so the caller can register pixel coordinates in the same cycle the counter moves.
module pixel_scan_counter #(
    parameter int BOX_W = 16,
    parameter int BOX_H = 8,
    localparam int DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1,
    localparam int DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           enable,
    output logic [DXW-1:0] dxNext,
    output logic [DYW-1:0] dyNext,
    output logic           last
);

    logic [DXW-1:0] dx;
    logic [DYW-1:0] dy;

    always_comb begin
        dxNext = dx;
        dyNext = dy;
        if (clear) begin
            dxNext = '0;
            dyNext = '0;
        end else if (enable) begin
            if (dx == DXW'(BOX_W - 1)) begin
                dxNext = '0;
                dyNext = (dy == DYW'(BOX_H - 1)) ? '0 : dy + DYW'(1);
            end else begin
                dxNext = dx + DXW'(1);
            end
        end
    end

    assign last = (dx == DXW'(BOX_W - 1)) && (dy == DYW'(BOX_H - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            dx <= '0;
            dy <= '0;
        end else begin
            dx <= dxNext;
            dy <= dyNext;
        end
    end

endmodule

// File: rtl/box_drawer.sv
// Draw-handshake responder: latches a lane/row, rasterises a filled box into the
// VGA adapter one pixel per clock, then pulses shapeDone for one cycle.
module box_drawer
    import display_pkg::*;
#(
    parameter int SCREEN_W   = display_pkg::SCREEN_W,
    parameter int SCREEN_H   = display_pkg::SCREEN_H,
    parameter int BOX_W      = 16,
    parameter int BOX_H      = 8,
    parameter int LANE_X0    = display_pkg::LANE_X0,
    parameter int LANE_PITCH = display_pkg::LANE_PITCH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       loadStartAddress,
    input  logic       startingAddressLoaded,
    input  logic [1:0] boxCounter,
    input  logic [7:0] rowY,
    input  logic       noteOn,
    output logic [7:0] x,
    output logic [7:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       shapeDone
);

    localparam int DXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int DYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;

    drawState_t state, stateNext;

    logic [1:0] idxReg;
    logic [7:0] rowReg;
    logic [7:0] x0Reg;
    logic       noteReg;

    logic latchEn;
    logic clearScan;
    logic enableScan;
    logic drawPixel;
    logic doneNext;

    logic [DXW-1:0] dxNext;
    logic [DYW-1:0] dyNext;
    logic           scanLast;

    logic [8:0] pixX9;
    logic [8:0] pixY9;
    logic       pixVisible;

    pixel_scan_counter #(
        .BOX_W(BOX_W),
        .BOX_H(BOX_H)
    ) u_scan (
        .clock (clock),
        .reset (reset),
        .clear (clearScan),
        .enable(enableScan),
        .dxNext(dxNext),
        .dyNext(dyNext),
        .last  (scanLast)
    );

    always_comb begin
        stateNext  = state;
        latchEn    = 1'b0;
        clearScan  = 1'b0;
        enableScan = 1'b0;
        drawPixel  = 1'b0;
        doneNext   = 1'b0;
        case (state)
            S_IDLE, S_LOADED: begin
                // In IDLE a new load wins; in LOADED the draw command wins.
                if (loadStartAddress && (state == S_IDLE || !startingAddressLoaded)) begin
                    latchEn   = 1'b1;
                    stateNext = S_LOADED;
                end else if (startingAddressLoaded) begin
                    if (idxReg == NO_BOX) begin
                        doneNext  = 1'b1;
                        stateNext = S_DONE;
                    end else begin
                        clearScan = 1'b1;
                        drawPixel = 1'b1;
                        stateNext = S_DRAW;
                    end
                end
            end
            S_DRAW: begin
                if (scanLast) begin
                    doneNext  = 1'b1;
                    stateNext = S_DONE;
                end else begin
                    enableScan = 1'b1;
                    drawPixel  = 1'b1;
                end
            end
            S_DONE: stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Coordinates of the pixel the counter is about to hold; 9-bit so clipping sees overflow.
    always_comb begin
        pixX9      = {1'b0, x0Reg} + 9'(dxNext);
        pixY9      = {1'b0, rowReg} + 9'(dyNext);
        pixVisible = (pixX9 < 9'(SCREEN_W)) && (pixY9 < 9'(SCREEN_H));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            idxReg    <= '0;
            rowReg    <= '0;
            noteReg   <= 1'b0;
            x0Reg     <= 8'(LANE_X0);
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            shapeDone <= 1'b0;
        end else begin
            state     <= stateNext;
            plot      <= drawPixel && pixVisible;
            shapeDone <= doneNext;
            if (latchEn) begin
                idxReg  <= boxCounter;
                rowReg  <= rowY;
                noteReg <= noteOn;
                x0Reg   <= 8'(LANE_X0) + 8'(LANE_PITCH) * {6'b0, boxCounter};
            end
            if (drawPixel) begin
                x      <= pixX9[7:0];
                y      <= pixY9[7:0];
                colour <= noteReg ? C_NOTE : C_BG;
            end
        end
    end

endmodule

// File: tb/tb_box_drawer.sv
// Directed self-checking bench for box_drawer: single boxes, clipping, the
// empty-lane slot, reset mid-draw and back-to-back controller timing.
module tb_box_drawer;

    logic       clock = 1'b0;
    logic       reset;
    logic       loadStartAddress;
    logic       startingAddressLoaded;
    logic [1:0] boxCounter;
    logic [7:0] rowY;
    logic       noteOn;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       shapeDone;

    int checks   = 0;
    int failures = 0;

    box_drawer dut (
        .clock                (clock),
        .reset                (reset),
        .loadStartAddress     (loadStartAddress),
        .startingAddressLoaded(startingAddressLoaded),
        .boxCounter           (boxCounter),
        .rowY                 (rowY),
        .noteOn               (noteOn),
        .x                    (x),
        .y                    (y),
        .colour               (colour),
        .plot                 (plot),
        .shapeDone            (shapeDone)
    );

    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Loads (optionally) and draws one box, then watches 140 cycles after the draw edge.
    task automatic runBox(input string tag, input bit doLoad, input logic [1:0] idx,
                          input logic [7:0] row, input logic note, input int expPlots,
                          input int expX0, input int expRow, input logic [2:0] expColour,
                          input int expDoneAt);
        int plots = 0, dones = 0, doneAt = 0, coordErr = 0, colourErr = 0;
        logic firstPlot = 1'b0;
        logic [7:0] firstX = '0, firstY = '0;
        int k;
        if (doLoad) begin
            @(posedge clock); #1;
            loadStartAddress = 1'b1; boxCounter = idx; rowY = row; noteOn = note;
        end
        @(posedge clock); #1;
        loadStartAddress = 1'b0; startingAddressLoaded = 1'b1;
        @(posedge clock); #1;
        startingAddressLoaded = 1'b0;
        for (int n = 1; n <= 140; n++) begin
            @(negedge clock);
            if (n == 1) begin
                firstPlot = plot; firstX = x; firstY = y;
            end
            if (plot === 1'b1) begin
                plots++;
                k = n - 1;
                if (x !== 8'(expX0 + k % 16) || y !== 8'(expRow + k / 16)) coordErr++;
                if (colour !== expColour) colourErr++;
            end
            if (shapeDone === 1'b1) begin
                dones++;
                if (doneAt == 0) doneAt = n;
            end
        end
        checkValue({tag, "_plots"}, plots, expPlots);
        checkValue({tag, "_doneCount"}, dones, 1);
        checkValue({tag, "_doneAt"}, doneAt, expDoneAt);
        checkValue({tag, "_firstPlot"}, {31'b0, firstPlot}, (expPlots > 0) ? 1 : 0);
        if (expPlots > 0) begin
            checkValue({tag, "_firstX"}, firstX, expX0);
            checkValue({tag, "_firstY"}, firstY, expRow);
        end
        checkValue({tag, "_coordErr"}, coordErr, 0);
        checkValue({tag, "_colourErr"}, colourErr, 0);
        checkValue({tag, "_plotAfter"}, {31'b0, plot}, 0);
    endtask

    int   boxIdx [3] = '{0, 1, 2};
    int   boxRow [3] = '{10, 50, 90};
    int   boxX0  [3] = '{40, 100, 160};

    initial begin
        int plots, dones, doneAt, maxX, totalPlots, totalDones, n;
        reset = 1'b1;
        loadStartAddress = 1'b0;
        startingAddressLoaded = 1'b0;
        boxCounter = '0;
        rowY = '0;
        noteOn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkValue("rst_plot", {31'b0, plot}, 0);
        checkValue("rst_done", {31'b0, shapeDone}, 0);
        checkValue("rst_xy", {16'b0, x, y}, 0);
        checkValue("rst_colour", {29'b0, colour}, 0);
        reset = 1'b0;

        // Draw straight from IDLE uses reset-latched values: lane 0, row 0, background.
        runBox("idleDraw", 1'b0, 2'd0, 8'd0, 1'b0, 128, 40, 0, 3'b000, 129);
        runBox("lane1", 1'b1, 2'd1, 8'd20, 1'b1, 128, 100, 20, 3'b010, 129);
        runBox("clipBottom", 1'b1, 2'd0, 8'd176, 1'b0, 64, 40, 176, 3'b000, 129);
        runBox("noBox", 1'b1, 2'd3, 8'd20, 1'b1, 0, 0, 0, 3'b000, 1);
        runBox("lane2", 1'b1, 2'd2, 8'd100, 1'b1, 128, 160, 100, 3'b010, 129);

        // Reset during pixel 50 of a draw.
        @(posedge clock); #1;
        loadStartAddress = 1'b1; boxCounter = 2'd1; rowY = 8'd30; noteOn = 1'b1;
        @(posedge clock); #1;
        loadStartAddress = 1'b0; startingAddressLoaded = 1'b1;
        @(posedge clock); #1;
        startingAddressLoaded = 1'b0;
        repeat (50) @(negedge clock);
        checkValue("midDraw_plot", {31'b0, plot}, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkValue("abort_plot", {31'b0, plot}, 0);
        checkValue("abort_done", {31'b0, shapeDone}, 0);
        reset = 1'b0;
        plots = 0; dones = 0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clock);
            if (plot === 1'b1) plots++;
            if (shapeDone === 1'b1) dones++;
        end
        checkValue("abort_quietPlots", plots, 0);
        checkValue("abort_quietDone", dones, 0);
        runBox("afterAbort", 1'b1, 2'd1, 8'd20, 1'b1, 128, 100, 20, 3'b010, 129);

        // Back-to-back boxes; stray handshake pulses during DRAW must be ignored.
        totalPlots = 0; totalDones = 0;
        for (int b = 0; b < 3; b++) begin
            @(posedge clock); #1;
            loadStartAddress = 1'b1; boxCounter = 2'(boxIdx[b]); rowY = 8'(boxRow[b]); noteOn = 1'b1;
            @(posedge clock); #1;
            loadStartAddress = 1'b0; startingAddressLoaded = 1'b1;
            @(posedge clock); #1;
            startingAddressLoaded = 1'b0;
            plots = 0; dones = 0; doneAt = 0; maxX = 0; n = 0;
            while (doneAt == 0 && n < 200) begin
                @(negedge clock);
                n++;
                if (plot === 1'b1) begin
                    plots++;
                    if (int'(x) > maxX) maxX = int'(x);
                end
                if (shapeDone === 1'b1) begin
                    dones++;
                    doneAt = n;
                end
                startingAddressLoaded = (n == 30 || n == 90);
                loadStartAddress = (n == 60 || n == 90);
                boxCounter = (n == 60 || n == 90) ? 2'd3 : 2'(boxIdx[b]);
                rowY = (n == 60 || n == 90) ? 8'd200 : 8'(boxRow[b]);
            end
            startingAddressLoaded = 1'b0;
            loadStartAddress = 1'b0;
            checkValue($sformatf("b2b%0d_doneAt", b), doneAt, 129);
            checkValue($sformatf("b2b%0d_maxX", b), maxX, boxX0[b] + 15);
            totalPlots += plots;
            totalDones += dones;
        end
        @(negedge clock);
        if (shapeDone === 1'b1) totalDones++;
        checkValue("b2b_totalPlots", totalPlots, 384);
        checkValue("b2b_totalDones", totalDones, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
